// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared states, size codes and strobe-to-size encoding for the sram-like bridges
package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } busStateT;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int STRB_MAX = 16;

  typedef struct packed {
    logic [1:0] size;
    logic       legal;
  } sizeEncT;

  // Full strobe -> word, one aligned pair -> half, single bit -> byte; anything else is illegal.
  function automatic sizeEncT strb_to_size(input logic [STRB_MAX-1:0] wen, input int strbW);
    logic [STRB_MAX-1:0] w;
    int ones;
    logic alignedPair;
    sizeEncT r;
    w = wen;
    ones = 0;
    alignedPair = 1'b0;
    for (int i = 0; i < STRB_MAX / 2; i++) begin
      ones = ones + int'(w[0]) + int'(w[1]);
      if (w[1:0] == 2'b11) alignedPair = 1'b1;
      w = w >> 2;
    end
    r.legal = 1'b1;
    if (ones == strbW) begin
      r.size = SIZE_W;
    end else if (ones == 2 && alignedPair) begin
      r.size = SIZE_H;
    end else if (ones == 1) begin
      r.size = SIZE_B;
    end else begin
      r.size  = SIZE_W;
      r.legal = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/strb_size_enc.sv
// rtl/strb_size_enc.sv - byte strobe to bus size code with legality flag
module strb_size_enc
  import mem_bus_pkg::*;
#(
  parameter int STRB_W = 4
) (
  input  logic [STRB_W-1:0] wen,
  output logic [1:0]        size,
  output logic              legal
);

  sizeEncT enc;

  always_comb begin
    enc = strb_to_size(STRB_MAX'(wen), STRB_W);
  end

  assign size  = enc.size;
  assign legal = enc.legal;

endmodule

// File: rtl/sram_like_bridge.sv
// rtl/sram_like_bridge.sv - CPU memory channel to single-outstanding sram-like bus bridge
module sram_like_bridge
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int STRB_W    = DATA_W / 8,
  parameter int INST_MODE = 0,
  parameter int READ_SIZE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic [STRB_W-1:0] cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              cpu_longest_stall,
  input  logic              cpu_flush,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  busStateT state, stateNext, dbgState;
  logic cancel, cancelNext, rbufLoad;
  logic capture, done, dataOk, isWrite, encLegal;
  logic [1:0] encSize;
  logic wrQ;
  logic [1:0] sizeQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ, rbuf;

  strb_size_enc #(.STRB_W(STRB_W)) uEnc (
    .wen  (cpu_wen),
    .size (encSize),
    .legal(encLegal)
  );

  assign isWrite  = (INST_MODE == 0) && (|cpu_wen);
  assign dbgState = ((state == ADDR || state == DATA) && cancel) ? DRAIN : state;
  assign dataOk   = (state == DATA) && bus_data_ok;
  assign done     = (dataOk && !cancel) || (state == HOLD);
  // A drained transaction's data_ok frees the bus, so a waiting access may be captured in that cycle.
  assign capture  = cpu_en && !cpu_flush && (state == IDLE || (dbgState == DRAIN && dataOk));

  always_comb begin
    stateNext  = state;
    cancelNext = cancel;
    rbufLoad   = 1'b0;
    case (state)
      IDLE: if (capture) stateNext = ADDR;
      ADDR: begin
        if (cpu_flush) cancelNext = 1'b1;
        if (bus_addr_ok) stateNext = DATA;
      end
      DATA: begin
        if (bus_data_ok) begin
          cancelNext = 1'b0;
          if (cancel) begin
            stateNext = capture ? ADDR : IDLE;
          end else if (cpu_longest_stall) begin
            stateNext = HOLD;
            rbufLoad  = 1'b1;
          end else begin
            stateNext = IDLE;
          end
        end else if (cpu_flush) begin
          cancelNext = 1'b1;
        end
      end
      HOLD: if (!cpu_longest_stall || cpu_flush) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cancel <= 1'b0;
    end else begin
      state  <= stateNext;
      cancel <= cancelNext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrQ    <= 1'b0;
      sizeQ  <= SIZE_B;
      addrQ  <= '0;
      wdataQ <= '0;
      rbuf   <= '0;
    end else begin
      if (capture) begin
        wrQ    <= isWrite;
        sizeQ  <= isWrite ? encSize : 2'(READ_SIZE);
        addrQ  <= cpu_addr;
        wdataQ <= (INST_MODE != 0) ? '0 : cpu_wdata;
      end
      if (rbufLoad) rbuf <= bus_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && capture && isWrite) assert (encLegal);
  end

  // Reset gates the stall so a held pipeline is released while the bridge is cleared.
  assign cpu_stall = rst && cpu_en && !done && !cpu_flush;
  assign cpu_rdata = (dataOk && !cancel) ? bus_rdata : rbuf;
  assign bus_req   = (state == ADDR);
  assign bus_wr    = wrQ;
  assign bus_size  = sizeQ;
  assign bus_addr  = addrQ;
  assign bus_wdata = wdataQ;

endmodule

// File: tb/tb_sram_like_bridge.sv
// tb/tb_sram_like_bridge.sv - self-checking bench for sram_like_bridge
module tb_sram_like_bridge;

  logic clk = 1'b0;
  logic rst;
  logic cpu_en, cpu_longest_stall, cpu_flush;
  logic [3:0] cpu_wen;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic cpu_stall;
  logic bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0] bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  logic iEn, iStall, iReq, iWr, iAddrOk, iDataOk;
  logic [3:0] iWen;
  logic [31:0] iAddr, iWdata, iCpuRdata, iBusAddr, iBusWdata, iBusRdata;
  logic [1:0] iSize;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_like_bridge dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cpu_longest_stall(cpu_longest_stall), .cpu_flush(cpu_flush), .bus_req(bus_req),
    .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  sram_like_bridge #(.INST_MODE(1), .READ_SIZE(2)) dutInst (
    .clk(clk), .rst(rst), .cpu_en(iEn), .cpu_wen(iWen), .cpu_addr(iAddr),
    .cpu_wdata(iWdata), .cpu_rdata(iCpuRdata), .cpu_stall(iStall),
    .cpu_longest_stall(cpu_longest_stall), .cpu_flush(cpu_flush), .bus_req(iReq),
    .bus_wr(iWr), .bus_size(iSize), .bus_addr(iBusAddr), .bus_wdata(iBusWdata),
    .bus_addr_ok(iAddrOk), .bus_data_ok(iDataOk), .bus_rdata(iBusRdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] refSize(input logic [3:0] wen);
    case ($countones(wen))
      4: return 2'd2;
      2: return (wen == 4'b0011 || wen == 4'b1100) ? 2'd1 : 2'd2;
      1: return 2'd0;
      default: return 2'd2;
    endcase
  endfunction

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // One full access against a bus that accepts after aDly and answers after dDly waits;
  // hold is the number of cycles the rest of the pipeline keeps stalling after data_ok.
  task automatic access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int aDly, input int dDly, input int hold);
    bit isWr;
    logic [1:0] expSize;
    isWr = (wen != 4'b0);
    expSize = isWr ? refSize(wen) : 2'd2;
    cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
    cpu_longest_stall = 1'b0; cpu_flush = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    @(negedge clk);
    check("capture_stall", 32'(cpu_stall), 32'd1);
    check("capture_req", 32'(bus_req), 32'd0);
    nextCycle();
    for (int k = 0; k <= aDly; k++) begin
      bus_addr_ok = (k == aDly);
      @(negedge clk);
      check("addr_req", 32'(bus_req), 32'd1);
      check("addr_addr", bus_addr, addr);
      check("addr_wr", 32'(bus_wr), 32'(isWr));
      check("addr_size", 32'(bus_size), 32'(expSize));
      check("addr_stall", 32'(cpu_stall), 32'd1);
      if (isWr) check("addr_wdata", bus_wdata, wdata);
      nextCycle();
    end
    bus_addr_ok = 1'b0;
    for (int k = 0; k <= dDly; k++) begin
      bus_data_ok = (k == dDly);
      bus_rdata = (k == dDly) ? rdata : $urandom;
      cpu_longest_stall = (k == dDly) && (hold > 0);
      @(negedge clk);
      check("data_stall", 32'(cpu_stall), (k == dDly) ? 32'd0 : 32'd1);
      check("data_req", 32'(bus_req), 32'd0);
      if (k == dDly && !isWr) check("data_rdata", cpu_rdata, rdata);
      nextCycle();
    end
    bus_data_ok = 1'b0;
    for (int h = 0; h < hold; h++) begin
      cpu_longest_stall = (h < hold - 1);
      bus_rdata = $urandom;
      @(negedge clk);
      check("hold_stall", 32'(cpu_stall), 32'd0);
      if (!isWr) check("hold_rdata", cpu_rdata, rdata);
      nextCycle();
    end
    cpu_en = 1'b0; cpu_longest_stall = 1'b0;
    @(negedge clk);
    check("idle_stall", 32'(cpu_stall), 32'd0);
    check("idle_req", 32'(bus_req), 32'd0);
    nextCycle();
  endtask

  logic [3:0] wenTbl [8];
  logic [31:0] r2;

  initial begin
    wenTbl = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    rst = 1'b0; cpu_en = 1'b0; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0;
    cpu_longest_stall = 1'b0; cpu_flush = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    iEn = 1'b0; iWen = '0; iAddr = '0; iWdata = '0; iAddrOk = 1'b0; iDataOk = 1'b0; iBusRdata = '0;

    @(negedge clk);
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    nextCycle();
    rst = 1'b1;
    nextCycle();

    access(4'b0000, 32'hBFC00000, 32'h0, 32'h3C1D0000, 0, 0, 0);
    access(4'b0100, 32'h80001002, 32'h00AB0000, 32'h0, 0, 0, 0);
    access(4'b0000, 32'h80002000, 32'h0, 32'h12345678, 0, 0, 3);

    // Flush in ADDR, addr_ok two cycles late, new access waits for the drain.
    cpu_en = 1'b1; cpu_wen = 4'b0; cpu_addr = 32'h80003000;
    @(negedge clk); check("fl_cap_stall", 32'(cpu_stall), 32'd1);
    nextCycle();
    cpu_flush = 1'b1;
    @(negedge clk);
    check("fl_stall", 32'(cpu_stall), 32'd0);
    check("fl_req", 32'(bus_req), 32'd1);
    nextCycle();
    cpu_flush = 1'b0; cpu_addr = 32'h80004000;
    @(negedge clk);
    check("dr_req", 32'(bus_req), 32'd1);
    check("dr_addr", bus_addr, 32'h80003000);
    check("dr_stall", 32'(cpu_stall), 32'd1);
    nextCycle();
    bus_addr_ok = 1'b1;
    @(negedge clk);
    check("dr_req2", 32'(bus_req), 32'd1);
    check("dr_stall2", 32'(cpu_stall), 32'd1);
    nextCycle();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("dr_dok_stall", 32'(cpu_stall), 32'd1);
    check("dr_dropped", 32'(cpu_rdata !== 32'hDEADBEEF), 32'd1);
    nextCycle();
    bus_data_ok = 1'b0; bus_addr_ok = 1'b1;
    @(negedge clk);
    check("new_req", 32'(bus_req), 32'd1);
    check("new_addr", bus_addr, 32'h80004000);
    check("new_stall", 32'(cpu_stall), 32'd1);
    check("new_dropped", 32'(cpu_rdata !== 32'hDEADBEEF), 32'd1);
    nextCycle();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; r2 = $urandom; bus_rdata = r2;
    @(negedge clk);
    check("new_done_stall", 32'(cpu_stall), 32'd0);
    check("new_rdata", cpu_rdata, r2);
    nextCycle();
    bus_data_ok = 1'b0; cpu_en = 1'b0;
    nextCycle();

    // Instruction-mode channel ignores strobes.
    iEn = 1'b1; iWen = 4'b1111; iAddr = 32'hBFC00010; iWdata = $urandom;
    @(negedge clk); check("i_cap_stall", 32'(iStall), 32'd1);
    nextCycle();
    iAddrOk = 1'b1;
    @(negedge clk);
    check("i_req", 32'(iReq), 32'd1);
    check("i_wr", 32'(iWr), 32'd0);
    check("i_size", 32'(iSize), 32'd2);
    check("i_addr", iBusAddr, 32'hBFC00010);
    nextCycle();
    iAddrOk = 1'b0; iDataOk = 1'b1; iBusRdata = 32'h24080001;
    @(negedge clk);
    check("i_stall", 32'(iStall), 32'd0);
    check("i_rdata", iCpuRdata, 32'h24080001);
    nextCycle();
    iDataOk = 1'b0; iEn = 1'b0;
    nextCycle();

    // Asynchronous reset while waiting in DATA.
    cpu_en = 1'b1; cpu_wen = 4'b0; cpu_addr = 32'h80005000;
    nextCycle();
    bus_addr_ok = 1'b1;
    nextCycle();
    bus_addr_ok = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("ar_req", 32'(bus_req), 32'd0);
    check("ar_stall", 32'(cpu_stall), 32'd0);
    check("ar_rdata", cpu_rdata, 32'd0);
    nextCycle();
    cpu_en = 1'b0;
    rst = 1'b1;
    nextCycle();
    access(4'b0000, 32'h80006000, 32'h0, 32'hCAFEF00D, 1, 1, 0);

    for (int n = 0; n < 25; n++) begin
      access(wenTbl[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_like_bridge.md
Name: sram_like_bridge

Overview:
- Converts one CPU memory channel into a single-outstanding sram-like bus transaction: CPU side is en/wen/addr/wdata/rdata with a stall back-pressure output; bus side is req/wr/size/addr/wdata with addr_ok/data_ok/rdata.
- This is the parametrised successor of the CPU's plain inst/data RAM interface. One instance serves the instruction channel and one serves the data channel.
- Each instance produces the i_stallF / d_stallM stall inputs for the core.
- Beyond the plain interface, it adds:
  - byte-strobe-to-size encoding;
  - read-data holding while the rest of the pipeline is stalled;
  - discarding of transactions cancelled by an exception flush.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- STRB_W, DATA_W/8, byte-strobe width.
- INST_MODE, 0: when 1, the channel is read-only; bus_wr is forced to 0, and cpu_wen/cpu_wdata are ignored.
- READ_SIZE, 2, value driven on bus_size for reads (log2 of bytes).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- cpu_en  in  1  access request this cycle.
- cpu_wen  in  STRB_W  byte write strobes; all zero means read.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load/fetch data; valid in the cycle cpu_stall falls for a read.
- cpu_stall  out  1  hold the requesting pipeline stage.
- cpu_longest_stall  in  1  OR of all other pipeline stall sources; the pipeline cannot advance while it is high.
- cpu_flush  in  1  exception flush; the current access is abandoned.
- bus_req  out  1  request valid.
- bus_wr  out  1  1 = write.
- bus_size  out  2  0 = byte, 1 = half, 2 = word.
- bus_addr  out  ADDR_W  request address.
- bus_wdata  out  DATA_W  write data.
- bus_addr_ok  in  1  address phase accepted.
- bus_data_ok  in  1  data phase complete; bus_rdata valid.
- bus_rdata  in  DATA_W  read data.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; cancel = 0; all registers cleared;
  - bus_req = 0, cpu_stall = 0, cpu_rdata = 0.
- States: IDLE, ADDR, DATA, HOLD, DRAIN.
- IDLE:
  - If cpu_en & !cpu_flush: latch wr, size, addr, wdata, then go to ADDR.
  - Request capture costs one cycle, so cpu_stall = 1 in this cycle.
- ADDR:
  - bus_req = 1, driven from the latched registers; the request stays stable until bus_addr_ok.
  - On bus_addr_ok, go to DATA. A simultaneous bus_data_ok in the same cycle is not permitted by the bus.
- DATA:
  - Wait for bus_data_ok.
  - On data_ok with cancel = 0:
    - if cpu_longest_stall = 0, go to IDLE; cpu_rdata = bus_rdata combinationally; cpu_stall = 0 this cycle;
    - else latch bus_rdata into rbuf and go to HOLD; cpu_stall = 0 from this cycle on.
  - On data_ok with cancel = 1: go to IDLE; data is dropped; cancel clears.
- HOLD:
  - cpu_rdata = rbuf; cpu_stall = 0.
  - Go to IDLE on the first cycle with cpu_longest_stall = 0; the pipeline consumes rbuf in that cycle.
  - cpu_flush in HOLD also goes to IDLE.
- Flush:
  - cpu_flush in ADDR or DATA sets cancel. The bus request is never withdrawn: ADDR still waits for addr_ok.
  - cpu_stall is 0 in the flush cycle.
  - ADDR/DATA with cancel = 1 is reported as DRAIN for debug. In DRAIN, cpu_stall = cpu_en: a new access must wait.
  - A new request can be captured in the same cycle as the cancelled data_ok.
- Size encoding for writes:
  - popcount(wen) = 4 → 2;
  - 2 contiguous bits at an aligned half → 1;
  - 1 bit → 0;
  - any other pattern → 2, with a sim-only assertion.
- Address and data pass-through: bus_addr = latched cpu_addr unmodified; bus_wdata = latched wdata unmodified. The bus applies the strobes via addr/size.
- cpu_stall, general case: cpu_stall = cpu_en & !done, where done = (DATA & data_ok & !cancel) | HOLD. The IDLE and DRAIN cases above follow from this.
- Reset during ADDR/DATA: the bridge returns to IDLE immediately. Keeping the bus coherent is the interconnect's responsibility, since the interconnect shares the same reset.
- Latency, zero-wait bus: en → addr_ok → data_ok gives a read result in the 3rd cycle after cpu_en is first seen.

Decomposition:
- Shared package `mem_bus_pkg`:
  - state encoding localparams (IDLE/ADDR/DATA/HOLD/DRAIN);
  - size codes SIZE_B/SIZE_H/SIZE_W;
  - function strb_to_size(wen).
- One sub-module is natural: `strb_size_enc` (wen → size plus legality flag), reused by the uncached data path later.

Test Plan:
- Word read, zero-wait bus: cpu_en = 1, addr = 0xBFC00000, addr_ok in cycle 1, data_ok in cycle 2 with rdata 0x3C1D0000 → bus_req high for exactly 1 cycle; cpu_stall high in cycles 0–1 and low in cycle 2; cpu_rdata = 0x3C1D0000.
- Byte store: wen = 0100, addr = 0x80001002, wdata = 0x00AB0000 → bus_wr = 1, bus_size = 0, addr/wdata unchanged; stall clears on data_ok.
- Hold: data_ok arrives while cpu_longest_stall = 1 for 3 more cycles, rdata 0x12345678 → cpu_stall = 0; cpu_rdata stays 0x12345678 in all 4 cycles; back to IDLE after longest_stall falls.
- Flush in ADDR with addr_ok delayed 2 cycles:
  - bus_req is held until addr_ok;
  - data_ok rdata 0xDEADBEEF never appears on cpu_rdata;
  - a new cpu_en issued during the drain sees cpu_stall = 1 until the drain data_ok, then its request is captured.
- INST_MODE = 1 with cpu_wen = 1111 → bus_wr = 0, bus_size = READ_SIZE.
- rst low asserted mid-DATA → bus_req = 0 and cpu_stall = 0 asynchronously; the next access completes normally after rst releases.
